// File: rtl/gpio_pkg.sv
// Shared constants for the memory-mapped GPIO controller: register byte
// offsets inside the 256-byte window.
package gpio_pkg;

  localparam int unsigned GPIO_WINDOW_BYTES = 256;

  localparam logic [7:0] GPIO_OUT_OFS    = 8'h00;
  localparam logic [7:0] GPIO_DIR_OFS    = 8'h04;
  localparam logic [7:0] GPIO_IN_OFS     = 8'h08;
  localparam logic [7:0] GPIO_SET_OFS    = 8'h0C;
  localparam logic [7:0] GPIO_CLR_OFS    = 8'h10;
  localparam logic [7:0] GPIO_IRQ_EN_OFS = 8'h14;
  localparam logic [7:0] GPIO_EDGE_OFS   = 8'h18;
  localparam logic [7:0] GPIO_STATUS_OFS = 8'h1C;

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage flop chain bringing asynchronous pad inputs into the clock
// domain; the last stage is the synchronised value.
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: window decode, register file, atomic
// set/clear, synchronised inputs with edge-latched status and interrupt.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [31:0]      rdata,
  output logic             rd_valid,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic             hit;
  logic             wr_hit;
  logic             rd_hit;
  logic [7:0]       reg_ofs;
  logic [WIDTH-1:0] wval;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] dir_reg;
  logic [WIDTH-1:0] ien_reg;
  logic [WIDTH-1:0] edge_reg;
  logic [WIDTH-1:0] status_reg;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] in_prev;
  logic [WIDTH-1:0] events;
  logic [WIDTH-1:0] w1c;
  logic [31:0]      rd_word;
  logic             unused_bits;

  assign hit         = (addr[31:8] == BASE_ADDR[31:8]);
  assign wr_hit      = wr_en && hit;
  assign rd_hit      = rd_en && hit;
  assign reg_ofs     = {addr[7:2], 2'b00};
  assign wval        = wdata[WIDTH-1:0];
  assign unused_bits = ^{addr[1:0], wdata};

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gpio_in),
    .q     (in_sync)
  );

  // EDGE bit selects falling (1) or rising (0) per pin
  assign events = (in_sync & ~in_prev & ~edge_reg) | (~in_sync & in_prev & edge_reg);
  assign w1c    = (wr_hit && reg_ofs == GPIO_STATUS_OFS) ? wval : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg  <= '0;
      dir_reg  <= '0;
      ien_reg  <= '0;
      edge_reg <= '0;
    end else if (wr_hit) begin
      case (reg_ofs)
        GPIO_OUT_OFS:    out_reg  <= wval;
        GPIO_DIR_OFS:    dir_reg  <= wval;
        GPIO_SET_OFS:    out_reg  <= out_reg | wval;
        GPIO_CLR_OFS:    out_reg  <= out_reg & ~wval;
        GPIO_IRQ_EN_OFS: ien_reg  <= wval;
        GPIO_EDGE_OFS:   edge_reg <= wval;
        default: ;
      endcase
    end
  end

  // A fresh event on a bit overrides a W1C of that bit in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_reg <= '0;
      in_prev    <= '0;
      irq        <= 1'b0;
    end else begin
      status_reg <= (status_reg & ~w1c) | events;
      in_prev    <= in_sync;
      irq        <= |(status_reg & ien_reg);
    end
  end

  always_comb begin
    rd_word = '0;
    case (reg_ofs)
      GPIO_OUT_OFS:    rd_word[WIDTH-1:0] = out_reg;
      GPIO_DIR_OFS:    rd_word[WIDTH-1:0] = dir_reg;
      GPIO_IN_OFS:     rd_word[WIDTH-1:0] = in_sync;
      GPIO_IRQ_EN_OFS: rd_word[WIDTH-1:0] = ien_reg;
      GPIO_EDGE_OFS:   rd_word[WIDTH-1:0] = edge_reg;
      GPIO_STATUS_OFS: rd_word[WIDTH-1:0] = status_reg;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_hit;
      if (rd_hit) rdata <= rd_word;
    end
  end

  assign gpio_out = out_reg;
  assign gpio_oe  = dir_reg;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: a per-cycle behavioural model of the register
// map checked against an 8-pin instance, plus literal checks on both builds.
module tb_gpio_ctrl;

  localparam int          W    = 8;
  localparam int          S    = 2;
  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [W-1:0] gpio_in = '0;

  logic [31:0]  rdata;
  logic         rd_valid;
  logic [W-1:0] gpio_out;
  logic [W-1:0] gpio_oe;
  logic         irq;

  logic [31:0] rdata4;
  logic        rd_valid4;
  logic [3:0]  gpio_out4;
  logic [3:0]  gpio_oe4;
  logic        irq4;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] m_out, m_dir, m_ien, m_edge, m_status;
  logic         m_irq, m_rd_valid;
  logic [31:0]  m_rdata;
  logic [W-1:0] hist [0:S];
  logic [W-1:0] mv_cur, mv_old, mv_ev, mv_w1c;
  logic         mv_nirq, mv_hit;
  logic [7:0]   mv_ofs;

  gpio_ctrl #(.WIDTH(W), .BASE_ADDR(BASE), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wr_en(wr_en),
    .rd_en(rd_en), .rdata(rdata), .rd_valid(rd_valid), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  gpio_ctrl #(.WIDTH(4), .BASE_ADDR(BASE), .SYNC_STAGES(S)) dut4 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wr_en(wr_en),
    .rd_en(rd_en), .rdata(rdata4), .rd_valid(rd_valid4), .gpio_in(gpio_in[3:0]),
    .gpio_out(gpio_out4), .gpio_oe(gpio_oe4), .irq(irq4)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [7:0] ofs);
    logic [31:0] v;
    v = '0;
    case (ofs)
      8'h00: v[W-1:0] = m_out;
      8'h04: v[W-1:0] = m_dir;
      8'h08: v[W-1:0] = hist[S-1];
      8'h14: v[W-1:0] = m_ien;
      8'h18: v[W-1:0] = m_edge;
      8'h1C: v[W-1:0] = m_status;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Model: pad samples age through a history array; IN is the sample taken
  // S-1 edges ago, and an event needs the last two IN values.
  initial begin
    m_out = '0; m_dir = '0; m_ien = '0; m_edge = '0; m_status = '0;
    m_irq = 1'b0; m_rd_valid = 1'b0; m_rdata = '0;
    for (int i = 0; i <= S; i++) hist[i] = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_out = '0; m_dir = '0; m_ien = '0; m_edge = '0; m_status = '0;
        m_irq = 1'b0; m_rd_valid = 1'b0; m_rdata = '0;
        for (int i = 0; i <= S; i++) hist[i] = '0;
      end else begin
        mv_cur  = hist[S-1];
        mv_old  = hist[S];
        mv_ev   = (mv_cur & ~mv_old & ~m_edge) | (~mv_cur & mv_old & m_edge);
        mv_nirq = |(m_status & m_ien);
        mv_hit  = (addr[31:8] == BASE[31:8]);
        mv_ofs  = {addr[7:2], 2'b00};
        mv_w1c  = '0;
        m_rd_valid = rd_en && mv_hit;
        if (m_rd_valid) m_rdata = modelRead(mv_ofs);
        if (wr_en && mv_hit) begin
          case (mv_ofs)
            8'h00: m_out  = wdata[W-1:0];
            8'h04: m_dir  = wdata[W-1:0];
            8'h0C: m_out  = m_out | wdata[W-1:0];
            8'h10: m_out  = m_out & ~wdata[W-1:0];
            8'h14: m_ien  = wdata[W-1:0];
            8'h18: m_edge = wdata[W-1:0];
            8'h1C: mv_w1c = wdata[W-1:0];
            default: ;
          endcase
        end
        m_status = (m_status & ~mv_w1c) | mv_ev;
        m_irq    = mv_nirq;
        for (int i = S; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = gpio_in;
      end
      #1;
      checkOutput("cyc_gpio_out", {24'h0, gpio_out}, {24'h0, m_out});
      checkOutput("cyc_gpio_oe",  {24'h0, gpio_oe},  {24'h0, m_dir});
      checkOutput("cyc_irq",      {31'h0, irq},      {31'h0, m_irq});
      checkOutput("cyc_rd_valid", {31'h0, rd_valid}, {31'h0, m_rd_valid});
      checkOutput("cyc_rdata",    rdata,             m_rdata);
    end
  end

  task automatic applyStimulus(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    wr_en = w; rd_en = r; addr = a; wdata = d;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic writeReg(input logic [7:0] ofs, input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, BASE + {24'h0, ofs}, d);
  endtask

  task automatic readReg(input logic [7:0] ofs);
    applyStimulus(1'b0, 1'b1, BASE + {24'h0, ofs}, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset_gpio_out", {24'h0, gpio_out}, 32'h0);
    checkOutput("reset_gpio_oe",  {24'h0, gpio_oe},  32'h0);
    checkOutput("reset_irq",      {31'h0, irq},      32'h0);
    checkOutput("reset_rdata",    rdata,             32'h0);

    // 0xA5 | 0x0A = 0xAF, then clearing bits 7 and 0 leaves 0x2E
    writeReg(8'h00, 32'hA5);
    writeReg(8'h04, 32'hFF);
    writeReg(8'h0C, 32'h0A);
    writeReg(8'h10, 32'h81);
    checkOutput("seq_gpio_out", {24'h0, gpio_out}, 32'h2E);
    checkOutput("seq_gpio_oe",  {24'h0, gpio_oe},  32'hFF);
    readReg(8'h00);
    checkOutput("read_out", rdata, 32'h0000_002E);
    checkOutput("read_out_valid", {31'h0, rd_valid}, 32'h1);
    idle(1);
    checkOutput("valid_pulse", {31'h0, rd_valid}, 32'h0);
    checkOutput("rdata_hold", rdata, 32'h0000_002E);

    applyStimulus(1'b1, 1'b1, BASE, 32'h11);
    checkOutput("rdw_old", rdata, 32'h2E);
    readReg(8'h00);
    checkOutput("rdw_new", rdata, 32'h11);
    readReg(8'h04);
    checkOutput("b2b_dir", rdata, 32'hFF);
    readReg(8'h0C);
    checkOutput("set_reads0", rdata, 32'h0);

    writeReg(8'h14, 32'h01);
    writeReg(8'h18, 32'h00);
    gpio_in[0] = 1'b1;
    idle(3);
    checkOutput("irq_not_yet", {31'h0, irq}, 32'h0);
    idle(1);
    checkOutput("irq_rise", {31'h0, irq}, 32'h1);
    readReg(8'h1C);
    checkOutput("status_rise", rdata, 32'h01);
    writeReg(8'h1C, 32'h01);
    idle(1);
    checkOutput("irq_cleared", {31'h0, irq}, 32'h0);
    readReg(8'h08);
    checkOutput("in_reg", rdata, 32'h01);

    writeReg(8'h18, 32'h04);
    gpio_in[2] = 1'b1;
    idle(4);
    readReg(8'h1C);
    checkOutput("no_rise_in_fall_mode", rdata, 32'h0);
    gpio_in[2] = 1'b0;
    idle(2);
    writeReg(8'h1C, 32'h04);
    readReg(8'h1C);
    checkOutput("set_beats_clear", rdata, 32'h04);
    writeReg(8'h1C, 32'h04);
    readReg(8'h1C);
    checkOutput("w1c_clears", rdata, 32'h0);

    writeReg(8'h00, 32'hFFFF_FFFF);
    checkOutput("w8_gpio_out", {24'h0, gpio_out}, 32'hFF);
    checkOutput("w4_gpio_out", {28'h0, gpio_out4}, 32'hF);
    readReg(8'h00);
    checkOutput("w8_read_out", rdata, 32'h0000_00FF);
    checkOutput("w4_read_out", rdata4, 32'h0000_000F);
    writeReg(8'h20, 32'hFFFF_FFFF);
    readReg(8'h20);
    checkOutput("unmapped_read", rdata, 32'h0);
    checkOutput("unmapped_valid", {31'h0, rd_valid}, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h0000_0000, 32'h0);
    applyStimulus(1'b0, 1'b1, BASE + 32'h5, 32'h0);
    checkOutput("unaligned_dir", rdata, 32'hFF);
    readReg(8'h00);
    checkOutput("miss_write_ignored", rdata, 32'hFF);
    checkOutput("w4_miss_write_ignored", rdata4, 32'hF);
    applyStimulus(1'b0, 1'b1, 32'h1234_5600, 32'h0);
    checkOutput("miss_no_valid", {31'h0, rd_valid}, 32'h0);
    checkOutput("w4_miss_no_valid", {31'h0, rd_valid4}, 32'h0);
    checkOutput("miss_rdata_hold", rdata, 32'hFF);

    rd_en = 1'b1; addr = BASE;
    #2 rst_n = 1'b0;
    @(negedge clk);
    rd_en = 1'b0;
    checkOutput("midrd_gpio_out", {24'h0, gpio_out}, 32'h0);
    checkOutput("midrd_gpio_oe",  {24'h0, gpio_oe},  32'h0);
    checkOutput("midrd_rd_valid", {31'h0, rd_valid}, 32'h0);
    checkOutput("midrd_rdata",    rdata,             32'h0);
    rst_n = 1'b1;
    idle(1);
    checkOutput("post_rst_no_valid", {31'h0, rd_valid}, 32'h0);
    readReg(8'h00);
    checkOutput("post_rst_out", rdata, 32'h0);
    idle(2);
    readReg(8'h1C);
    checkOutput("rise_at_release", rdata, 32'h01);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
